// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, NZCV flags, logic/shift ops.
// Define ALU_SEQ_MUL_EN to build the multi-cycle radix-2 shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] S_MUL  = 2'd1;
`endif
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             live_q;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flg_q, flg_d;

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   shl_w;
  logic [WIDTH:0]   shr_w;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_v;

  function automatic logic [3:0] mk_flags(
    input logic [WIDTH-1:0] r,
    input logic             c,
    input logic             v
  );
    return {r[WIDTH-1], (r == '0), c, v};
  endfunction

  // Single-cycle datapath; the extra top/bottom bit catches carry and shift-out.
  always_comb begin
    sh    = b[SHW-1:0];
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    shl_w = {1'b0, a} << sh;
    shr_w = {a, 1'b0} >> sh;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        alu_r = add_w[WIDTH-1:0];
        alu_c = add_w[WIDTH];
        alu_v = (a[WIDTH-1] == b[WIDTH-1])
             && (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r = sub_w[WIDTH-1:0];
        alu_c = sub_w[WIDTH];
        alu_v = (a[WIDTH-1] != b[WIDTH-1])
             && (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_SHL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        alu_r = shr_w[WIDTH:1];
        alu_c = shr_w[0];
      end
      OP_MUL: alu_r = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [2*WIDTH-1:0] prod_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH:0]     psum;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  // Upper half accumulates, multiplier bits drain out of the lower half.
  always_comb begin
    psum      = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {psum, prod_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    flg_d   = flg_q;
`ifdef ALU_SEQ_MUL_EN
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && live_q) begin
`ifdef ALU_SEQ_MUL_EN
          if (opcode == OP_MUL) begin
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            res_d   = alu_r;
            flg_d   = mk_flags(alu_r, alu_c, alu_v);
            state_d = S_DONE;
          end
`else
          res_d   = alu_r;
          flg_d   = mk_flags(alu_r, alu_c, alu_v);
          state_d = S_DONE;
`endif
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        prod_d = prod_step;
        if (cnt_q == CNT_LAST) begin
          res_d   = prod_step[WIDTH-1:0];
          flg_d   = mk_flags(prod_step[WIDTH-1:0],
                             |prod_step[2*WIDTH-1:WIDTH],
                             |prod_step[2*WIDTH-1:WIDTH]);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + SHW'(1);
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

`ifdef ALU_SEQ_MUL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else begin
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign in_ready  = live_q && (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = res_q;
  assign flags     = flg_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=16) checked against a
// behavioural model every cycle out_valid is high, plus literal expectations.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  opcode = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
  } exp_t;
  exp_t expq[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: plain integer arithmetic; returns {N,Z,C,V,result}.
  function automatic logic [19:0] model(input logic [2:0] op,
                                        input logic [15:0] va,
                                        input logic [15:0] vb);
    int unsigned ua, ub, sh, p;
    int sa, sb, s;
    logic [15:0] r;
    logic c, v;
    ua = va; ub = vb;
    sa = $signed(va); sb = $signed(vb);
    sh = vb % 16;
    r = '0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        r = 16'(ua + ub); c = (ua + ub) > 65535;
        s = sa + sb; v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        r = 16'(ua - ub); c = (ua >= ub);
        s = sa - sb; v = (s > 32767) || (s < -32768);
      end
      3'd2: r = va & vb;
      3'd3: r = va | vb;
      3'd4: r = va ^ vb;
      3'd5: begin
        r = 16'(ua << sh);
        c = (sh != 0) && (((ua >> (16 - sh)) & 1) != 0);
      end
      3'd6: begin
        r = 16'(ua >> sh);
        c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
      end
      default: begin
`ifdef ALU_SEQ_MUL_EN
        p = ua * ub;
        r = 16'(p);
        c = (p >> 16) != 0;
        v = c;
`else
        p = 0;
        r = 16'(p);
`endif
      end
    endcase
    return {r[15], (r == 16'h0000), c, v, r};
  endfunction

  // Single compare process: every cycle a result is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("model_result", 32'(result), 32'(expq[0].r));
        chk("model_flags", 32'(flags), 32'(expq[0].f));
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  task automatic accept(input logic [2:0] op, input logic [15:0] va,
                        input logic [15:0] vb);
    int n;
    logic [19:0] m;
    exp_t e;
    n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    opcode = op; a = va; b = vb; in_valid = 1'b1;
    m = model(op, va, vb);
    e.r = m[15:0];
    e.f = m[19:16];
    expq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    opcode = 3'($urandom);
  endtask

  task automatic wait_out(input int exp_lat);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk); #1; lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("out_valid_after_take", 32'(out_valid), 32'd0);
    chk("in_ready_after_take", 32'(in_ready), 32'd1);
  endtask

  function automatic int lat_of(input logic [2:0] op);
    return (op == 3'd7) ? MUL_LAT : 1;
  endfunction

  task automatic run(input logic [2:0] op, input logic [15:0] va,
                     input logic [15:0] vb, input logic [15:0] er,
                     input logic [3:0] ef);
    accept(op, va, vb);
    wait_out(lat_of(op));
    chk("lit_result", 32'(result), 32'(er));
    chk("lit_flags", 32'(flags), 32'(ef));
    release_out();
  endtask

  task automatic run_m(input logic [2:0] op, input logic [15:0] va,
                       input logic [15:0] vb);
    accept(op, va, vb);
    wait_out(lat_of(op));
    release_out();
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } vec_t;

  vec_t vt[10] = '{
    '{3'd0, 16'h1234, 16'h4321}, '{3'd1, 16'h0000, 16'h0000},
    '{3'd2, 16'hF0F0, 16'h3C3C}, '{3'd3, 16'h0F00, 16'h00F0},
    '{3'd4, 16'hFFFF, 16'h1234}, '{3'd5, 16'h4001, 16'h0002},
    '{3'd6, 16'h0003, 16'hFFF2}, '{3'd7, 16'hFFFF, 16'hFFFF},
    '{3'd7, 16'h0007, 16'h0009}, '{3'd1, 16'h7FFF, 16'hFFFF}
  };

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", 32'(in_ready), 32'd1);

    // out_ready while idle is ignored
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_out_ready_no_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    run(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110);
    run(3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011);
    run(3'd1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1000);
    run(3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001);
    run(3'd4, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100);
    run(3'd6, 16'h0005, 16'h0001, 16'h0002, 4'b0010);
    run(3'd5, 16'h00F0, 16'h0014, 16'h0F00, 4'b0000);
    run(3'd5, 16'h8000, 16'h0000, 16'h8000, 4'b1000);
    run(3'd5, 16'h0003, 16'h000F, 16'h8000, 4'b1010);
    run(3'd6, 16'h8000, 16'h000F, 16'h0001, 4'b0000);
`ifdef ALU_SEQ_MUL_EN
    run(3'd7, 16'h0100, 16'h0100, 16'h0000, 4'b0111);
    run(3'd7, 16'h00FF, 16'h0003, 16'h02FD, 4'b0000);
`else
    run(3'd7, 16'h0003, 16'h0004, 16'h0000, 4'b0100);
`endif

    foreach (vt[i]) run_m(vt[i].op, vt[i].a, vt[i].b);

    // Back-pressure: result held while out_ready stays low
    accept(3'd5, 16'h8001, 16'h0001);
    wait_out(1);
    for (int k = 0; k < 5; k++) begin
      chk("hold_result", 32'(result), 32'h0002);
      chk("hold_flags", 32'(flags), 32'h2);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    release_out();

    // Reset aborts an op in flight
    accept(3'd7, 16'h1234, 16'h0F0F);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    expq.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1 chk("abort_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("abort_in_ready_high", 32'(in_ready), 32'd1);
    run(3'd0, 16'h0002, 16'h0003, 16'h0005, 4'b0000);

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
